// File: rtl/amstrad_rom_pkg.sv
// Shared ROM page layout for the boot loader and the upload reader, plus the
// reader state encoding.
package amstrad_rom_pkg;

  localparam logic [8:0] PG_LOW    = 9'h000;
  localparam logic [8:0] PG_BASIC  = 9'h100;
  localparam logic [8:0] PG_AMSDOS = 9'h107;
  localparam logic [8:0] PG_MF2    = 9'h1FF;

  typedef enum logic [1:0] {IDLE, FILL, ARM, WAIT} rd_state_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] page;
    logic [1:0] bank;
  } rom_map_t;

  // Maps an ioctl byte address onto an SDRAM page/bank; valid=0 means unmapped.
  function automatic rom_map_t rom_page_map(input logic [7:0]  index,
                                            input logic [24:0] addr,
                                            input logic [8:0]  exp_page);
    rom_map_t   m;
    logic [10:0] sel;
    m   = '0;
    sel = addr[24:14];
    if (index == 8'd0) begin
      if (sel < 11'd8) begin
        m.valid = 1'b1;
        m.bank  = {1'b0, sel[2]};
        case (sel[1:0])
          2'd0:    m.page = PG_LOW;
          2'd1:    m.page = PG_BASIC;
          2'd2:    m.page = PG_AMSDOS;
          default: m.page = PG_MF2;
        endcase
      end
    end else if (addr[24:22] == 3'b000) begin
      // Expansion pages wrap within their 256-page window.
      m.valid = 1'b1;
      m.page  = {exp_page[8], exp_page[7:0] + addr[21:14]};
      m.bank  = {1'b0, &index[7:6]};
    end
    return m;
  endfunction

endpackage

// File: rtl/rom_upload_reader.sv
// Serves HPS ioctl upload reads from SDRAM using the loader's page layout,
// returning each byte with an ioctl_wait handshake.
module rom_upload_reader
  import amstrad_rom_pkg::*;
#(
  parameter int unsigned RD_WAIT_CE = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [8:0]  exp_page,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_rd,
  output logic [22:0] mem_a,
  output logic [1:0]  mem_bank,
  input  logic [7:0]  mem_dout,
  output logic [24:0] bytes_read,
  output logic        proto_err
);

  localparam int CNT_W = (RD_WAIT_CE < 1) ? 1 : $clog2(RD_WAIT_CE + 1);

  rd_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic        upload_q;
  logic [8:0]  exp_page_reg;

  logic        upload_rise;
  logic [8:0]  exp_page_eff;
  rom_map_t    map;
  logic [24:0] bytes_inc;

  assign upload_rise  = ioctl_upload & ~upload_q;
  // A request landing on the session's first cycle must see the new base page.
  assign exp_page_eff = upload_rise ? exp_page : exp_page_reg;
  assign map          = rom_page_map(ioctl_index, ioctl_addr, exp_page_eff);
  assign bytes_inc    = (&bytes_read) ? bytes_read : bytes_read + 25'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      upload_q     <= 1'b0;
      exp_page_reg <= '0;
      ioctl_din    <= '0;
      ioctl_wait   <= 1'b0;
      mem_rd       <= 1'b0;
      mem_a        <= '0;
      mem_bank     <= '0;
      bytes_read   <= '0;
      proto_err    <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (!ioctl_upload) begin
        // Session closed: abandon any transfer without touching data or count.
        state      <= IDLE;
        ioctl_wait <= 1'b0;
        mem_rd     <= 1'b0;
      end else begin
        if (upload_rise) begin
          bytes_read   <= '0;
          proto_err    <= 1'b0;
          exp_page_reg <= exp_page;
        end
        if (ioctl_rd && state != IDLE)
          proto_err <= 1'b1;
        case (state)
          IDLE: begin
            if (ioctl_rd) begin
              ioctl_wait <= 1'b1;
              if (map.valid) begin
                mem_a    <= {map.page, ioctl_addr[13:0]};
                mem_bank <= map.bank;
                mem_rd   <= 1'b1;
                state    <= ARM;
              end else begin
                state <= FILL;
              end
            end
          end
          FILL: begin
            ioctl_din  <= FILL_BYTE;
            ioctl_wait <= 1'b0;
            bytes_read <= bytes_inc;
            state      <= IDLE;
          end
          ARM: begin
            // The strobe seen here issues the SDRAM read.
            if (ce_ref) begin
              mem_rd <= 1'b0;
              cnt    <= CNT_W'(RD_WAIT_CE);
              state  <= WAIT;
            end
          end
          WAIT: begin
            if (ce_ref) begin
              if (cnt == '0) begin
                ioctl_din  <= mem_dout;
                ioctl_wait <= 1'b0;
                bytes_read <= bytes_inc;
                state      <= IDLE;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_upload_reader.sv
// Directed bench for rom_upload_reader with a behavioural SDRAM read port.
module tb_rom_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_ref;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [8:0]  exp_page;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [22:0] mem_a;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_dout = 8'h00;
  logic [24:0] bytes_read;
  logic        proto_err;

  int n_checks = 0;
  int n_fails  = 0;

  rom_upload_reader #(.RD_WAIT_CE(1), .FILL_BYTE(8'hFF)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .exp_page(exp_page),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_rd(mem_rd), .mem_a(mem_a), .mem_bank(mem_bank),
    .mem_dout(mem_dout), .bytes_read(bytes_read), .proto_err(proto_err)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: answers the address presented while mem_rd meets ce_ref.
  logic [3:0]  ce_div = 4'd0;
  int          strobe_cnt = 0;
  int          mem_rd_cycles = 0;
  logic [22:0] last_a = '0;
  logic [1:0]  last_bank = '0;
  assign ce_ref = (ce_div == 4'hF);

  function automatic logic [7:0] mem_model(input logic [1:0] b, input logic [22:0] a);
    if (b == 2'd0 && a == 23'h400005) return 8'hA5;
    return a[7:0] ^ {6'b0, b} ^ 8'h3C;
  endfunction

  always @(posedge clk_sys) begin
    ce_div <= ce_div + 4'd1;
    if (mem_rd) mem_rd_cycles <= mem_rd_cycles + 1;
    if (mem_rd && ce_ref) begin
      strobe_cnt <= strobe_cnt + 1;
      last_a     <= mem_a;
      last_bank  <= mem_bank;
      mem_dout   <= mem_model(mem_bank, mem_a);
    end
  end

  task automatic issue(input logic [24:0] a);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (ioctl_wait === 1'b1 && cyc < 100) begin
      @(negedge clk_sys);
      cyc++;
    end
    n_checks++;
    if (cyc >= 100) begin
      n_fails++;
      $display("FAIL handshake_timeout: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, cyc);
    end
  endtask

  task automatic wait_mem_rd(input logic level);
    int c;
    c = 0;
    while (mem_rd !== level && c < 60) begin
      @(negedge clk_sys);
      c++;
    end
    n_checks++;
    if (mem_rd !== level) begin
      n_fails++;
      $display("FAIL mem_rd_wait: mem_rd=%b after %0d cycles, required %b", mem_rd, c, level);
    end
  endtask

  task automatic new_session(input logic [7:0] idx, input logic [8:0] pg);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_index  = idx;
    exp_page     = pg;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ioctl_upload = 1'b0; ioctl_index = 8'd0; exp_page = 9'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if ({ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank, bytes_read, proto_err} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: din=%h wait=%b rd=%b a=%h bank=%h bytes=%h perr=%b, required all 0",
               ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank, bytes_read, proto_err);
    end
    reset = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if ({ioctl_wait, mem_rd, bytes_read} !== '0) begin
      n_fails++;
      $display("FAIL post_reset_idle: wait=%b rd=%b bytes=%h, required 0", ioctl_wait, mem_rd, bytes_read);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic;
    int s0, cyc;
    new_session(8'h00, 9'h000);
    s0 = strobe_cnt;
    issue(25'h004005);
    n_checks++;
    if (ioctl_wait !== 1'b1) begin
      n_fails++; $display("FAIL basic_wait_asserted: got %b required 1", ioctl_wait);
    end
    wait_done(cyc);
    n_checks++;
    if (ioctl_din !== 8'hA5) begin
      n_fails++; $display("FAIL basic_din: got %h required a5", ioctl_din);
    end
    n_checks++;
    if (last_a !== 23'h400005 || last_bank !== 2'd0) begin
      n_fails++; $display("FAIL basic_addr: got a=%h bank=%0d required a=400005 bank=0", last_a, last_bank);
    end
    n_checks++;
    if (strobe_cnt - s0 != 1) begin
      n_fails++; $display("FAIL basic_strobes: got %0d required 1", strobe_cnt - s0);
    end
    n_checks++;
    if (bytes_read !== 25'd1 || mem_rd !== 1'b0) begin
      n_fails++; $display("FAIL basic_count: got bytes=%0d rd=%b required bytes=1 rd=0", bytes_read, mem_rd);
    end
    n_checks++;
    if (cyc < 33 || cyc > 48) begin
      n_fails++; $display("FAIL basic_latency: got %0d cycles required 33..48", cyc);
    end
    $display("read idx=00 addr=004005 -> din=%h in %0d cycles", ioctl_din, cyc);
  endtask

  task automatic test_bank1_fill;
    int r0, cyc;
    issue(25'h01C000);
    wait_done(cyc);
    n_checks++;
    if (ioctl_din !== 8'h3D || last_a !== 23'h7FC000 || last_bank !== 2'd1) begin
      n_fails++; $display("FAIL bank1_read: got din=%h a=%h bank=%0d required din=3d a=7fc000 bank=1",
                          ioctl_din, last_a, last_bank);
    end
    $display("read idx=00 addr=01c000 -> din=%h", ioctl_din);
    r0 = mem_rd_cycles;
    issue(25'h020000);
    wait_done(cyc);
    n_checks++;
    if (cyc != 1 || ioctl_din !== 8'hFF) begin
      n_fails++; $display("FAIL fill_unmapped: got din=%h cycles=%0d required din=ff cycles=1", ioctl_din, cyc);
    end
    n_checks++;
    if (mem_rd_cycles != r0 || bytes_read !== 25'd3) begin
      n_fails++; $display("FAIL fill_no_mem: got rd_cycles=%0d bytes=%0d required rd_cycles=0 bytes=3",
                          mem_rd_cycles - r0, bytes_read);
    end
    $display("read idx=00 addr=020000 -> din=%h (fill)", ioctl_din);
  endtask

  task automatic test_expansion;
    int cyc;
    new_session(8'h41, 9'h0FE);
    exp_page = 9'h033;
    issue(25'h008010);
    wait_done(cyc);
    n_checks++;
    if (ioctl_din !== 8'h2C || last_a !== 23'h000010 || last_bank !== 2'd0) begin
      n_fails++; $display("FAIL exp_wrap: got din=%h a=%h bank=%0d required din=2c a=000010 bank=0",
                          ioctl_din, last_a, last_bank);
    end
    $display("read idx=41 addr=008010 -> din=%h", ioctl_din);
    ioctl_index = 8'hC1;
    issue(25'h008010);
    wait_done(cyc);
    n_checks++;
    if (ioctl_din !== 8'h2D || last_a !== 23'h000010 || last_bank !== 2'd1) begin
      n_fails++; $display("FAIL exp_bank1: got din=%h a=%h bank=%0d required din=2d a=000010 bank=1",
                          ioctl_din, last_a, last_bank);
    end
    $display("read idx=c1 addr=008010 -> din=%h", ioctl_din);
    issue(25'h400000);
    wait_done(cyc);
    n_checks++;
    if (cyc != 1 || ioctl_din !== 8'hFF || bytes_read !== 25'd3) begin
      n_fails++; $display("FAIL exp_unmapped: got din=%h cycles=%0d bytes=%0d required ff/1/3",
                          ioctl_din, cyc, bytes_read);
    end
    $display("read idx=c1 addr=400000 -> din=%h (fill)", ioctl_din);
  endtask

  task automatic test_back_to_back;
    int s0, cyc;
    new_session(8'h00, 9'h000);
    s0 = strobe_cnt;
    issue(25'h004005);
    wait_mem_rd(1'b0);
    issue(25'h020000);
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fails++; $display("FAIL proto_set: got %b required 1", proto_err);
    end
    wait_done(cyc);
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== 8'hA5 || bytes_read !== 25'd1 || ioctl_wait !== 1'b0 || strobe_cnt - s0 != 1) begin
      n_fails++; $display("FAIL proto_single: got din=%h bytes=%0d wait=%b strobes=%0d required a5/1/0/1",
                          ioctl_din, bytes_read, ioctl_wait, strobe_cnt - s0);
    end
    $display("read idx=00 addr=004005 with overlap -> din=%h perr=%b", ioctl_din, proto_err);
    new_session(8'h00, 9'h000);
    n_checks++;
    if (proto_err !== 1'b0 || bytes_read !== 25'd0) begin
      n_fails++; $display("FAIL proto_clear: got perr=%b bytes=%0d required 0/0", proto_err, bytes_read);
    end
  endtask

  task automatic test_abort;
    issue(25'h01C000);
    wait_mem_rd(1'b1);
    wait_mem_rd(1'b0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (ioctl_wait !== 1'b0 || mem_rd !== 1'b0) begin
      n_fails++; $display("FAIL abort_release: got wait=%b rd=%b required 0/0", ioctl_wait, mem_rd);
    end
    repeat (40) @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== 8'hA5 || bytes_read !== 25'd0) begin
      n_fails++; $display("FAIL abort_nodata: got din=%h bytes=%0d required a5/0", ioctl_din, bytes_read);
    end
    $display("read idx=00 addr=01c000 aborted -> din=%h", ioctl_din);
  endtask

  task automatic test_async_reset;
    int cyc;
    new_session(8'h00, 9'h000);
    issue(25'h004005);
    @(posedge clk_sys);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank, bytes_read, proto_err} !== '0) begin
      n_fails++;
      $display("FAIL async_reset: din=%h wait=%b rd=%b a=%h bank=%h bytes=%h perr=%b, required all 0",
               ioctl_din, ioctl_wait, mem_rd, mem_a, mem_bank, bytes_read, proto_err);
    end
    #2 reset = 1'b0;
    issue(25'h01C000);
    wait_done(cyc);
    n_checks++;
    if (ioctl_din !== 8'h3D || bytes_read !== 25'd1 || last_a !== 23'h7FC000) begin
      n_fails++; $display("FAIL after_reset_read: got din=%h bytes=%0d a=%h required 3d/1/7fc000",
                          ioctl_din, bytes_read, last_a);
    end
    $display("read idx=00 addr=01c000 after reset -> din=%h", ioctl_din);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bank1_fill();
    test_expansion();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
